// File: rtl/can_crc_pkg.sv
// Shared types and constants for the CAN CRC-15 sequencer.
package can_crc_pkg;
   localparam int                 CRC15_W    = 15;
   localparam logic [CRC15_W-1:0] CRC15_POLY = 15'h4599;
   localparam int                 CRC_WORD_W = 32;

   typedef enum logic [2:0] {
      IDLE,
      COLLECT,
      WORD,
      FLUSH,
      DONE
   } state_e;
endpackage

// File: rtl/crc15_step.sv
// Combinational CRC-15 advance over N data bits; data[N-1] is the oldest bit.
module crc15_step
   import can_crc_pkg::*;
#(
   parameter int N = 32
) (
   input  logic [CRC15_W-1:0] crc,
   input  logic [N-1:0]       data,
   output logic [CRC15_W-1:0] crc_next
);
   logic [CRC15_W-1:0] c;
   logic               fb;

   always_comb begin
      c  = crc;
      fb = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         fb = data[i] ^ c[CRC15_W-1];
         c  = {c[CRC15_W-2:0], 1'b0} ^ (fb ? CRC15_POLY : '0);
      end
      crc_next = c;
   end
endmodule

// File: rtl/can_crc_seq.sv
// CAN CRC-15 sequencer: packs frame bits into words for a parallel update, serially flushes the tail.
// Optional destuffing is enabled by defining CAN_CRC_SEQ_DESTUFF_EN.
//
// state   | meaning
// IDLE    | waiting for start, not accepting bits
// COLLECT | accepting bits into the pack register
// WORD    | one-cycle parallel update of a full pack word
// FLUSH   | serial update of the partial tail, oldest bit first
// DONE    | crc_out final, crc_valid pulse
module can_crc_seq
   import can_crc_pkg::*;
#(
   parameter int                 WORD_W   = CRC_WORD_W,
   parameter logic [CRC15_W-1:0] CRC_INIT = 15'h0000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               bit_valid,
   input  logic               bit_in,
   input  logic               bit_last,
   output logic               bit_ready,
   output logic               busy,
   output logic               crc_valid,
   output logic [CRC15_W-1:0] crc_out,
   output logic               stuff_err
);
   localparam int FILL_W = $clog2(WORD_W + 1);

   state_e             state_q, state_d;
   logic [CRC15_W-1:0] crc_q, crc_d;
   logic [WORD_W-1:0]  pack_q, pack_d;
   logic [FILL_W-1:0]  fill_q, fill_d;
   logic               last_q, last_d;
   logic               stuff_bit;
   logic               flush_bit;
   logic [CRC15_W-1:0] crc_word, crc_bit;

   crc15_step #(.N(WORD_W)) u_step_word (
      .crc      (crc_q),
      .data     (pack_q),
      .crc_next (crc_word)
   );

   crc15_step #(.N(1)) u_step_bit (
      .crc      (crc_q),
      .data     (flush_bit),
      .crc_next (crc_bit)
   );

   // Oldest unflushed bit sits at pack[fill-1].
   always_comb begin
      flush_bit = 1'b0;
      for (int i = 0; i < WORD_W; i++) begin
         if (fill_q == FILL_W'(i + 1)) flush_bit = pack_q[i];
      end
   end

`ifdef CAN_CRC_SEQ_DESTUFF_EN
   logic [2:0] run_cnt_q, run_cnt_d;
   logic       run_val_q, run_val_d;
   logic       stuff_err_q, stuff_err_d;

   assign stuff_bit = (run_cnt_q == 3'd5);
   assign stuff_err = stuff_err_q;

   always_comb begin
      run_cnt_d   = run_cnt_q;
      run_val_d   = run_val_q;
      stuff_err_d = 1'b0;
      if (start) begin
         run_cnt_d = '0;
         run_val_d = 1'b0;
      end else if (state_q == COLLECT && bit_valid) begin
         if (stuff_bit) begin
            run_cnt_d   = 3'd1;
            run_val_d   = bit_in;
            stuff_err_d = (bit_in == run_val_q);
         end else if (run_cnt_q == 3'd0 || bit_in != run_val_q) begin
            run_cnt_d = 3'd1;
            run_val_d = bit_in;
         end else begin
            run_cnt_d = run_cnt_q + 3'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         run_cnt_q   <= '0;
         run_val_q   <= 1'b0;
         stuff_err_q <= 1'b0;
      end else begin
         run_cnt_q   <= run_cnt_d;
         run_val_q   <= run_val_d;
         stuff_err_q <= stuff_err_d;
      end
   end
`else
   assign stuff_bit = 1'b0;
   assign stuff_err = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      crc_d     = crc_q;
      pack_d    = pack_q;
      fill_d    = fill_q;
      last_d    = last_q;
      bit_ready = 1'b0;
      crc_valid = 1'b0;

      case (state_q)
         IDLE: ;
         COLLECT: begin
            bit_ready = 1'b1;
            if (bit_valid) begin
               if (!stuff_bit) begin
                  pack_d = {pack_q[WORD_W-2:0], bit_in};
                  fill_d = fill_q + FILL_W'(1);
               end
               if (fill_d == FILL_W'(WORD_W)) begin
                  state_d = WORD;
                  last_d  = bit_last;
               end else if (bit_last) begin
                  // a trailing stuff bit on an empty pack has nothing left to flush
                  state_d = (fill_d == '0) ? DONE : FLUSH;
               end
            end
         end
         WORD: begin
            crc_d   = crc_word;
            fill_d  = '0;
            state_d = last_q ? DONE : COLLECT;
         end
         FLUSH: begin
            crc_d  = crc_bit;
            fill_d = fill_q - FILL_W'(1);
            if (fill_d == '0) state_d = DONE;
         end
         DONE: begin
            crc_valid = 1'b1;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (start) begin
         state_d = COLLECT;
         crc_d   = CRC_INIT;
         fill_d  = '0;
         last_d  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         crc_q   <= '0;
         pack_q  <= '0;
         fill_q  <= '0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         crc_q   <= crc_d;
         pack_q  <= pack_d;
         fill_q  <= fill_d;
         last_q  <= last_d;
      end
   end

   assign busy    = (state_q != IDLE);
   assign crc_out = crc_q;
endmodule

// File: tb/tb_can_crc_seq.sv
// Directed self-checking bench for can_crc_seq; expectations come from hand values and a serial CRC model.
module tb_can_crc_seq;
   logic        clk;
   logic        rst;
   logic        start;
   logic        bit_valid;
   logic        bit_in;
   logic        bit_last;
   logic        bit_ready;
   logic        busy;
   logic        crc_valid;
   logic [14:0] crc_out;
   logic        stuff_err;

   int n_assert = 0;
   int n_fail   = 0;
   int err_seen = 0;
   int bub_seen = 0;
   int obs_lat  = 0;

   can_crc_seq dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .bit_valid (bit_valid),
      .bit_in    (bit_in),
      .bit_last  (bit_last),
      .bit_ready (bit_ready),
      .busy      (busy),
      .crc_valid (crc_valid),
      .crc_out   (crc_out),
      .stuff_err (stuff_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      if (stuff_err === 1'b1) err_seen++;
   endtask

   // Serial reference: CRC, WORD bubbles seen mid-frame, valid latency after the last edge, stuff errors.
   task automatic model(input int n, input logic [127:0] bits, output logic [14:0] crc,
                        output int bub, output int lat, output int errs);
      int   run, fed, k;
      logic val, b, fb, stuff;
      crc = 15'h0000; bub = 0; errs = 0; run = 0; fed = 0; val = 1'b0; stuff = 1'b0;
      for (int i = 0; i < n; i++) begin
         b = bits[i];
`ifdef CAN_CRC_SEQ_DESTUFF_EN
         stuff = (run == 5);
`endif
         if (stuff) begin
            if (b == val) errs++;
            run = 1; val = b;
         end else begin
            fb  = b ^ crc[14];
            crc = {crc[13:0], 1'b0} ^ (fb ? 15'h4599 : 15'h0000);
            fed++;
            if (fed % 32 == 0 && i < n - 1) bub++;
            if (run == 0 || b != val) begin run = 1; val = b; end
            else run++;
         end
      end
      if (stuff) lat = fed % 32;
      else begin
         k   = ((fed - 1) % 32) + 1;
         lat = (k == 32) ? 1 : k;
      end
   endtask

   task automatic feed_bit(input logic b, input logic last);
      int waitc;
      bit_valid = 1'b1; bit_in = b; bit_last = last;
      waitc = 0;
      while (bit_ready !== 1'b1 && waitc < 50) begin
         tick(); waitc++; bub_seen++;
      end
      if (waitc >= 50) chk("ready_timeout", {31'b0, bit_ready}, 32'd1);
      tick();
   endtask

   task automatic run_frame(input string tag, input int n, input logic [127:0] bits, input bit do_start);
      logic [14:0] exp_crc, hold;
      int          exp_bub, exp_lat, exp_err;
      model(n, bits, exp_crc, exp_bub, exp_lat, exp_err);
      err_seen = 0; bub_seen = 0;
      if (do_start) begin
         start = 1'b1; tick(); start = 1'b0;
         chk({tag, " busy_after_start"}, {31'b0, busy}, 32'd1);
      end
      for (int i = 0; i < n; i++) feed_bit(bits[i], i == n - 1);
      bit_valid = 1'b0; bit_last = 1'b0; bit_in = 1'b0;
      obs_lat = 0;
      while (crc_valid !== 1'b1 && obs_lat < 100) begin
         tick(); obs_lat++;
      end
      chk({tag, " crc_valid"}, {31'b0, crc_valid}, 32'd1);
      chk({tag, " crc"}, {17'b0, crc_out}, {17'b0, exp_crc});
      chk({tag, " latency"}, obs_lat, exp_lat);
      chk({tag, " bubbles"}, bub_seen, exp_bub);
      hold = crc_out;
      tick();
      chk({tag, " stuff_err_count"}, err_seen, exp_err);
      chk({tag, " valid_one_cycle"}, {31'b0, crc_valid}, 32'd0);
      chk({tag, " busy_fall"}, {31'b0, busy}, 32'd0);
      chk({tag, " crc_hold"}, {17'b0, crc_out}, {17'b0, hold});
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [127:0] data, old;
      int           len, vcount;
      int           lens[7] = '{31, 32, 33, 64, 83, 96, 127};

      rst = 1'b1; start = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; bit_last = 1'b0;
      tick(); tick();
      chk("rst busy", {31'b0, busy}, 32'd0);
      chk("rst bit_ready", {31'b0, bit_ready}, 32'd0);
      chk("rst crc_valid", {31'b0, crc_valid}, 32'd0);
      chk("rst crc_out", {17'b0, crc_out}, 32'd0);
      chk("rst stuff_err", {31'b0, stuff_err}, 32'd0);
      rst = 1'b0;
      tick();
      chk("idle bit_ready", {31'b0, bit_ready}, 32'd0);

      // Single bit 1; a lone bit_last without bit_valid must not end the frame.
      start = 1'b1; tick(); start = 1'b0;
      bit_last = 1'b1; tick(); tick();
      chk("lone_last no_valid", {31'b0, crc_valid}, 32'd0);
      chk("lone_last busy", {31'b0, busy}, 32'd1);
      run_frame("one_bit", 1, 128'h1, 1'b0);
      chk("one_bit hand_crc", {17'b0, crc_out}, 32'h4599);
      chk("one_bit hand_lat", obs_lat, 32'd1);

      run_frame("bits_10", 2, 128'h1, 1'b1);
      chk("bits_10 hand_crc", {17'b0, crc_out}, 32'h4EAB);

      run_frame("zeros40", 40, 128'h0, 1'b1);
      chk("zeros40 hand_crc", {17'b0, crc_out}, 32'h0);
`ifndef CAN_CRC_SEQ_DESTUFF_EN
      chk("zeros40 hand_lat", obs_lat, 32'd8);
      chk("zeros40 hand_bub", bub_seen, 32'd1);
`endif

      // Stuffing patterns, bit i of the vector is the i-th transmitted bit.
      run_frame("stream_0000011", 7, 128'h60, 1'b1);
`ifdef CAN_CRC_SEQ_DESTUFF_EN
      chk("stream_0000011 hand_crc", {17'b0, crc_out}, 32'h4599);
`else
      chk("stream_0000011 hand_crc", {17'b0, crc_out}, 32'h0B32);
`endif
      run_frame("stream_000000", 6, 128'h0, 1'b1);
`ifdef CAN_CRC_SEQ_DESTUFF_EN
      chk("stream_000000 hand_err", err_seen, 32'd1);
      chk("stream_000000 hand_lat", obs_lat, 32'd5);
`else
      chk("stream_000000 hand_err", err_seen, 32'd0);
      chk("stream_000000 hand_lat", obs_lat, 32'd6);
`endif

      foreach (lens[j]) begin
         data = {$urandom, $urandom, $urandom, $urandom};
         run_frame($sformatf("len%0d", lens[j]), lens[j], data, 1'b1);
      end
      for (int j = 0; j < 3; j++) begin
         len  = $urandom_range(1, 127);
         data = {$urandom, $urandom, $urandom, $urandom};
         run_frame($sformatf("rand_len%0d", len), len, data, 1'b1);
      end

      // Abort an 83-bit frame at bit 50 with a bit offered alongside start.
      old = {$urandom, $urandom, $urandom, $urandom};
      start = 1'b1; tick(); start = 1'b0;
      for (int i = 0; i < 49; i++) feed_bit(old[i], 1'b0);
      start = 1'b1; bit_valid = 1'b1; bit_in = 1'b1; bit_last = 1'b0;
      tick();
      start = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
      chk("abort busy", {31'b0, busy}, 32'd1);
      data = {$urandom, $urandom, $urandom, $urandom};
      run_frame("abort_new83", 83, data, 1'b0);

      // Reset during FLUSH.
      start = 1'b1; tick(); start = 1'b0;
      for (int i = 0; i < 10; i++) feed_bit(i % 3 == 0, i == 9);
      bit_valid = 1'b0; bit_last = 1'b0;
      tick(); tick();
      chk("flush busy", {31'b0, busy}, 32'd1);
      chk("flush not_ready", {31'b0, bit_ready}, 32'd0);
      rst = 1'b1; tick();
      chk("midrst busy", {31'b0, busy}, 32'd0);
      chk("midrst crc_out", {17'b0, crc_out}, 32'd0);
      chk("midrst bit_ready", {31'b0, bit_ready}, 32'd0);
      chk("midrst stuff_err", {31'b0, stuff_err}, 32'd0);
      rst = 1'b0;
      vcount = 0;
      for (int i = 0; i < 15; i++) begin
         if (crc_valid === 1'b1) vcount++;
         tick();
      end
      chk("midrst no_valid", vcount, 32'd0);
      chk("midrst idle", {31'b0, busy}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
